// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
// Synchronizes the PLL lock flag, waits for lock to stay stable, holds the
// core reset for a few extra cycles, then releases it and produces
// phase-deterministic /2 and /4 clock enables. Lock losses seen while
// running are counted (saturating) for debug.
`timescale 1ns/1ps
module pll_reset_sequencer #(
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned HOLD_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pll_locked,
   output logic       sys_reset,
   output logic       locked_sync,
   output logic       ce_div2,
   output logic       ce_div4,
   output logic [7:0] lock_loss_count,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic        sync1_q, sync1_d;
   logic        sync2_q, sync2_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  phase_q, phase_d;
   logic        sys_reset_q, sys_reset_d;
   logic [7:0]  llc_q, llc_d;
   logic        run;

   // State and datapath registers; rst wins over every transition
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= WAIT_LOCK;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         cnt_q       <= '0;
         phase_q     <= '0;
         sys_reset_q <= 1'b1;
         llc_q       <= '0;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         cnt_q       <= cnt_d;
         phase_q     <= phase_d;
         sys_reset_q <= sys_reset_d;
         llc_q       <= llc_d;
      end
   end

   // Next state, stability counter, phase, reset and lock-loss bookkeeping
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sync1_d = pll_locked;
      sync2_d = sync1_q;
      case (state_q)
         WAIT_LOCK: begin
            if (sync2_q) begin
               state_d = STABILIZE;
               cnt_d   = '0;
            end
         end
         STABILIZE: begin
            // Lock loss takes precedence over reaching the terminal count
            if (!sync2_q) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == STABLE_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         HOLD: begin
            if (!sync2_q) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RUN: begin
            if (!sync2_q) begin
               state_d = WAIT_LOCK;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
         end
      endcase

      // Only losses out of RUN are counted; restarts during bring-up are not
      llc_d = llc_q;
      if ((state_q == RUN) && !sync2_q && (llc_q != 8'hFF)) begin
         llc_d = llc_q + 8'd1;
      end

      // Phase starts at 0 on the first RUN cycle so the enables are aligned
      // to the reset release
      phase_d = '0;
      if ((state_q == RUN) && (state_d == RUN)) begin
         phase_d = phase_q + 2'd1;
      end

      sys_reset_d = (state_d != RUN);
   end

   // Outputs decoded from registers only
   always_comb begin
      run             = (state_q == RUN);
      sys_reset       = sys_reset_q;
      locked_sync     = sync2_q;
      ce_div2         = run & phase_q[0];
      ce_div4         = run & (phase_q == 2'd3);
      lock_loss_count = llc_q;
      state_dbg       = state_q;
   end

endmodule
